// File: rtl/adc_seq_pkg.sv
// ADC sequencer shared types and defaults.
// Optional threshold alarm build macro: ADC_SEQ_THRESH_EN.
package adc_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_SAMPLE
   } state_t;

   localparam int DEF_NUM_CH     = 4;
   localparam int DEF_SETTLE_CYC = 3;
   localparam int DEF_AVG_LOG2   = 2;

   // Wide enough for 2^avg_log2 full-scale 8-bit samples.
   function automatic int acc_width(input int avg_log2);
      return 8 + avg_log2;
   endfunction

endpackage

// File: rtl/adc_seq_if.sv
// Result handshake bundle: producer is master, consumer is slave.
// Shared by adc_seq_ctrl and its consumer.
interface adc_seq_if #(
   parameter int CW = 2
);
   logic          res_valid;
   logic          res_ready;
   logic [7:0]    res_data;
   logic [CW-1:0] res_ch;

   modport master (
      output res_valid,
      output res_data,
      output res_ch,
      input  res_ready
   );

   modport slave (
      input  res_valid,
      input  res_data,
      input  res_ch,
      output res_ready
   );
endinterface

// File: rtl/adc_seq_avg.sv
// Clear/accumulate/shift datapath for the ADC sequencer.
// o_avg already includes the sample presented this cycle.
module adc_seq_avg
   import adc_seq_pkg::*;
#(
   parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_clr,
   input  logic       i_acc_en,
   input  logic [7:0] i_data,
   output logic [7:0] o_avg
);
   localparam int AW = acc_width(AVG_LOG2);

   logic [AW-1:0] r_acc;
   logic [AW-1:0] w_sum;

   assign w_sum = r_acc + AW'(i_data);
   assign o_avg = w_sum[AVG_LOG2 +: 8];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc <= '0;
      end else if (i_clr) begin
         r_acc <= '0;
      end else if (i_acc_en) begin
         r_acc <= w_sum;
      end
   end
endmodule

// File: rtl/adc_seq_ctrl.sv
// Round-robin ADC mux sequencer with averaging and result handshake.
// Define ADC_SEQ_THRESH_EN to add thresh/alarm ports.
module adc_seq_ctrl
   import adc_seq_pkg::*;
#(
   parameter int NUM_CH     = DEF_NUM_CH,
   parameter int SETTLE_CYC = DEF_SETTLE_CYC,
   parameter int AVG_LOG2   = DEF_AVG_LOG2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       en,
   input  logic [7:0]                 adc_data,
   output logic [$clog2(NUM_CH)-1:0]  ch_sel,
   output logic                       busy,
   output logic                       overrun,
`ifdef ADC_SEQ_THRESH_EN
   input  logic [7:0]                 thresh,
   output logic [NUM_CH-1:0]          alarm,
`endif
   adc_seq_if.master                  res
);
   localparam int CW = $clog2(NUM_CH);
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
   localparam logic [7:0] SAMPLE_LAST = 8'((1 << AVG_LOG2) - 1);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [7:0]    r_cnt;
   logic [CW-1:0] r_ch;
   logic          r_valid;
   logic [7:0]    r_data;
   logic [CW-1:0] r_res_ch;
   logic          r_overrun;
   logic          w_clr;
   logic          w_acc_en;
   logic          w_done;
   logic          w_load;
   logic [7:0]    w_avg;

   always_comb begin
      w_state_nxt = r_state;
      w_acc_en    = 1'b0;
      w_done      = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (en) w_state_nxt = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (r_cnt == SETTLE_LAST) w_state_nxt = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            w_acc_en = 1'b1;
            if (r_cnt == SAMPLE_LAST) begin
               w_done      = 1'b1;
               w_state_nxt = en ? ST_SETTLE : ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      w_clr = (w_state_nxt == ST_SETTLE) && (r_state != ST_SETTLE);
   end

   // Results are dropped rather than stalling the sampling cadence.
   assign w_load = w_done && (!r_valid || res.res_ready);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_ch    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_state_nxt != r_state || r_state == ST_IDLE) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 8'd1;
         end
         if (w_done) begin
            r_ch <= (r_ch == CW'(NUM_CH - 1)) ? '0 : r_ch + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid   <= 1'b0;
         r_data    <= '0;
         r_res_ch  <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (w_load) begin
            r_valid  <= 1'b1;
            r_data   <= w_avg;
            r_res_ch <= r_ch;
         end else if (r_valid && res.res_ready) begin
            r_valid <= 1'b0;
         end
         if (w_done && !w_load) r_overrun <= 1'b1;
      end
   end

`ifdef ADC_SEQ_THRESH_EN
   logic [NUM_CH-1:0] r_alarm;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_alarm <= '0;
      end else if (w_load) begin
         r_alarm[r_ch] <= (w_avg >= thresh);
      end
   end

   assign alarm = r_alarm;
`endif

   adc_seq_avg #(
      .AVG_LOG2 (AVG_LOG2)
   ) u_avg (
      .clk      (clk),
      .reset    (reset),
      .i_clr    (w_clr),
      .i_acc_en (w_acc_en),
      .i_data   (adc_data),
      .o_avg    (w_avg)
   );

   assign ch_sel        = r_ch;
   assign busy          = (r_state != ST_IDLE);
   assign overrun       = r_overrun;
   assign res.res_valid = r_valid;
   assign res.res_data  = r_data;
   assign res.res_ch    = r_res_ch;
endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Directed bench for adc_seq_ctrl at default parameters.
// Alarm checks are built only with ADC_SEQ_THRESH_EN.
module tb_adc_seq_ctrl;
   logic       clk;
   logic       reset;
   logic       en;
   logic [7:0] adc_data;
   logic [1:0] ch_sel;
   logic       busy;
   logic       overrun;
`ifdef ADC_SEQ_THRESH_EN
   logic [7:0] thresh;
   logic [3:0] alarm;
`endif

   adc_seq_if #(.CW(2)) res_if ();

   adc_seq_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .adc_data (adc_data),
      .ch_sel   (ch_sel),
      .busy     (busy),
      .overrun  (overrun),
`ifdef ADC_SEQ_THRESH_EN
      .thresh   (thresh),
      .alarm    (alarm),
`endif
      .res      (res_if.master)
   );

   int         n_tests;
   int         n_fail;
   int         cyc;
   bit         ramp;
   logic [7:0] cdata;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp_v);
      n_tests++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      adc_data = ramp ? 8'(cyc) : cdata;
   endtask

   task automatic run_to(input int c);
      while (cyc < c) tick();
   endtask

   // Leaves the bench in cycle 0 with en=1 and reset released.
   task automatic do_reset();
      reset = 1'b1;
      en    = 1'b0;
      tick();
      tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(res_if.res_valid), 32'd0);
      chk("rst_chsel", 32'(ch_sel), 32'd0);
      reset    = 1'b0;
      en       = 1'b1;
      cyc      = 0;
      adc_data = ramp ? 8'd0 : cdata;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      cyc     = 0;
      ramp    = 1'b1;
      cdata   = 8'h00;
      en      = 1'b0;
      reset   = 1'b1;
      adc_data = 8'h00;
      res_if.res_ready = 1'b1;
`ifdef ADC_SEQ_THRESH_EN
      thresh = 8'h80;
`endif

      // Continuous conversion, consumer always ready.
      do_reset();
      chk("rst_data", 32'(res_if.res_data), 32'd0);
      chk("rst_ovr", 32'(overrun), 32'd0);
      for (int r = 0; r < 5; r++) begin
         run_to(7 + 7 * r);
         chk("pre_valid", 32'(res_if.res_valid), 32'd0);
         chk("pre_chsel", 32'(ch_sel), 32'(r % 4));
         run_to(8 + 7 * r);
         chk("valid", 32'(res_if.res_valid), 32'd1);
         chk("res_ch", 32'(res_if.res_ch), 32'(r % 4));
         chk("res_data", 32'(res_if.res_data), 32'(5 + 7 * r));
         chk("post_chsel", 32'(ch_sel), 32'((r + 1) % 4));
         chk("busy", 32'(busy), 32'd1);
         run_to(9 + 7 * r);
         chk("drop_valid", 32'(res_if.res_valid), 32'd0);
      end
      chk("no_ovr", 32'(overrun), 32'd0);

      // Consumer never ready: first result held, second dropped.
      res_if.res_ready = 1'b0;
      do_reset();
      run_to(8);
      chk("hold_valid", 32'(res_if.res_valid), 32'd1);
      chk("hold_data", 32'(res_if.res_data), 32'd5);
      run_to(14);
      chk("ovr_before", 32'(overrun), 32'd0);
      run_to(15);
      chk("ovr_set", 32'(overrun), 32'd1);
      chk("ovr_data", 32'(res_if.res_data), 32'd5);
      chk("ovr_ch", 32'(res_if.res_ch), 32'd0);
      run_to(20);
      chk("ovr_sticky", 32'(overrun), 32'd1);

      // Drop en during channel 2 sampling.
      res_if.res_ready = 1'b1;
      do_reset();
      run_to(19);
      en = 1'b0;
      run_to(22);
      chk("stop_valid", 32'(res_if.res_valid), 32'd1);
      chk("stop_ch", 32'(res_if.res_ch), 32'd2);
      chk("stop_data", 32'(res_if.res_data), 32'd19);
      chk("stop_busy", 32'(busy), 32'd0);
      chk("stop_chsel", 32'(ch_sel), 32'd3);
      run_to(25);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_chsel", 32'(ch_sel), 32'd3);
      en = 1'b1;
      run_to(33);
      chk("resume_valid", 32'(res_if.res_valid), 32'd1);
      chk("resume_ch", 32'(res_if.res_ch), 32'd3);
      chk("resume_data", 32'(res_if.res_data), 32'd30);

      // Reset in the middle of sampling.
      do_reset();
      run_to(5);
      reset = 1'b1;
      tick();
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_valid", 32'(res_if.res_valid), 32'd0);
      chk("mrst_chsel", 32'(ch_sel), 32'd0);
      chk("mrst_data", 32'(res_if.res_data), 32'd0);
      chk("mrst_ch", 32'(res_if.res_ch), 32'd0);
      chk("mrst_ovr", 32'(overrun), 32'd0);
      run_to(9);
      chk("mrst_noresult", 32'(res_if.res_valid), 32'd0);
      reset = 1'b0;

`ifdef ADC_SEQ_THRESH_EN
      ramp  = 1'b0;
      cdata = 8'h80;
      do_reset();
      chk("alarm_rst", 32'(alarm), 32'd0);
      for (int r = 0; r < 4; r++) begin
         run_to(8 + 7 * r);
         chk("alarm_hi", 32'(alarm), 32'((1 << (r + 1)) - 1));
      end
      cdata = 8'h7F;
      for (int r = 4; r < 8; r++) begin
         run_to(8 + 7 * r);
         chk("alarm_lo", 32'(alarm), 32'(4'hF << (r - 3)) & 32'hF);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
